// File: rtl/struct_lane_pkg.sv
// Shared types for the lane arbiter: element/state layout, request record,
// clear-sequence states and the slice-range legality check.
package struct_lane_pkg;

    localparam int LANE_NUM_ELEM = 8;
    localparam int LANE_ELEM_W   = 8;
    localparam int LANE_FILL_W   = 16;
    localparam int LANE_IDX_W    = 3;
    localparam int LANE_DATA_W   = 16;

    typedef bit [LANE_ELEM_W-1:0] elem_t;

    typedef struct packed {
        elem_t [LANE_NUM_ELEM-1:0] a;
        bit    [LANE_FILL_W-1:0]   b;
    } lane_state_t;

    typedef struct packed {
        logic                   field;
        logic [LANE_IDX_W-1:0]  lo;
        logic [LANE_IDX_W-1:0]  hi;
        logic [LANE_DATA_W-1:0] data;
    } lane_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLR_A,
        ST_CLR_B
    } clr_state_e;

    // A slice is one element (hi == lo) or two adjacent elements (hi == lo+1),
    // entirely inside the array. hi >= lo plus hi in range covers lo as well.
    function automatic logic range_legal(input logic [LANE_IDX_W-1:0] lo,
                                         input logic [LANE_IDX_W-1:0] hi,
                                         input int                    n);
        logic [LANE_IDX_W:0] lo_x;
        logic [LANE_IDX_W:0] hi_x;
        lo_x = {1'b0, lo};
        hi_x = {1'b0, hi};
        return (int'(hi_x) < n) && ((hi_x == lo_x) || (hi_x == lo_x + 1'b1));
    endfunction

endpackage

// File: rtl/struct_lane_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: simultaneous requests go to the requester
// not granted last; the pointer moves only when a grant is taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid_i,
    input  logic       enable_i,
    output logic [1:0] grant_o
);

    // Index of the requester that wins a tie.
    logic prio_q;
    logic prio_d;

    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            if (valid_i == 2'b11) begin
                grant_o = prio_q ? 2'b10 : 2'b01;
            end else begin
                grant_o = valid_i;
            end
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (grant_o[0]) begin
            prio_d = 1'b1;
        end else if (grant_o[1]) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/struct_lane_arbiter.sv
// Packed {a, b} state register fed by two arbitrated slice-write requesters,
// with an element-by-element clear sequence that blocks requests while it runs.
module struct_lane_arbiter
    import struct_lane_pkg::*;
#(
    parameter int NUM_ELEM = LANE_NUM_ELEM,
    parameter int ELEM_W   = LANE_ELEM_W,
    parameter int FILL_W   = LANE_FILL_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [1:0]                        req_valid,
    output logic [1:0]                        req_ready,
    input  logic [1:0]                        req_field,
    input  logic [1:0][2:0]                   req_lo,
    input  logic [1:0][2:0]                   req_hi,
    input  logic [1:0][15:0]                  req_data,
    input  logic                              clr_start,
    output logic                              busy,
    output logic                              wr_err,
    output logic [NUM_ELEM*ELEM_W+FILL_W-1:0] state_o
);

    localparam int CNT_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

    clr_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NUM_ELEM-1:0][ELEM_W-1:0] a_q, a_d;
    logic [FILL_W-1:0]               b_q, b_d;
    logic                            wr_err_q, wr_err_d;

    logic      xfer;
    logic      sel;
    lane_req_t req_sel;
    logic      legal;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (req_valid),
        .enable_i (state_q == ST_IDLE),
        .grant_o  (req_ready)
    );

    // A grant always implies the matching valid, so any grant is a transfer.
    assign xfer = |req_ready;
    assign sel  = req_ready[1];

    always_comb begin
        req_sel = {req_field[sel], req_lo[sel], req_hi[sel], req_data[sel]};
        legal   = range_legal(req_sel.lo, req_sel.hi, NUM_ELEM);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d = ST_CLR_A;
                    cnt_d   = '0;
                end
            end
            ST_CLR_A: begin
                if (cnt_q == CNT_W'(NUM_ELEM - 1)) begin
                    state_d = ST_CLR_B;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CLR_B: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Requests and clearing never overlap: grants are held off outside IDLE.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        wr_err_d = 1'b0;
        if (xfer) begin
            if (req_sel.field) begin
                b_d = req_sel.data[FILL_W-1:0];
            end else if (!legal) begin
                wr_err_d = 1'b1;
            end else begin
                a_d[req_sel.lo] = req_sel.data[ELEM_W-1:0];
                if (req_sel.hi != req_sel.lo) begin
                    a_d[req_sel.hi] = req_sel.data[2*ELEM_W-1:ELEM_W];
                end
            end
        end
        if (state_q == ST_CLR_A) begin
            a_d[cnt_q] = '0;
        end
        if (state_q == ST_CLR_B) begin
            b_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign wr_err  = wr_err_q;
    assign state_o = {a_q, b_q};

endmodule

// File: tb/tb_struct_lane_arbiter.sv
// Bench for struct_lane_arbiter: table vectors, directed clear/reset sequences
// and randomized traffic against a byte-array reference model.
module tb_struct_lane_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [1:0]      vld;
    logic [1:0]      rdy;
    logic [1:0]      fld;
    logic [1:0][2:0] lo;
    logic [1:0][2:0] hi;
    logic [1:0][15:0] dat;
    logic            clr;
    logic            busy;
    logic            wr_err;
    logic [79:0]     st;

    struct_lane_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (vld),
        .req_ready (rdy),
        .req_field (fld),
        .req_lo    (lo),
        .req_hi    (hi),
        .req_data  (dat),
        .clr_start (clr),
        .busy      (busy),
        .wr_err    (wr_err),
        .state_o   (st)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: eight bytes, the filler, the requester granted last,
    // and the number of clear cycles still to run.
    byte unsigned ma[8];
    logic [15:0]  mb;
    int           last;
    int           clr_left;
    logic         merr;

    logic [1:0]  s_rdy;
    logic        s_busy;
    logic [79:0] s_st;

    typedef struct {
        logic [1:0]  v;
        logic        f;
        logic [2:0]  l;
        logic [2:0]  h;
        logic [15:0] d;
        logic [1:0]  er;
        logic [79:0] es;
        logic        ee;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] ex);
        checks++;
        if (act !== ex) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, ex);
        end
    endtask

    function automatic void m_reset();
        for (int k = 0; k < 8; k++) ma[k] = 8'h00;
        mb       = 16'h0;
        last     = 1;
        clr_left = 0;
        merr     = 1'b0;
    endfunction

    function automatic logic [79:0] m_state();
        logic [79:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v[16+8*k +: 8] = ma[k];
        v[15:0] = mb;
        return v;
    endfunction

    function automatic logic [1:0] m_ready();
        if (clr_left != 0) return 2'b00;
        if (vld == 2'b11) return (last == 0) ? 2'b10 : 2'b01;
        return vld;
    endfunction

    function automatic void m_step(input logic [1:0] g);
        int k;
        if (rst) begin
            m_reset();
            return;
        end
        merr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (g[i]) begin
                last = i;
                if (fld[i]) begin
                    mb = dat[i];
                end else if (hi[i] == lo[i]) begin
                    ma[lo[i]] = dat[i][7:0];
                end else if (int'(hi[i]) == int'(lo[i]) + 1) begin
                    ma[hi[i]] = dat[i][15:8];
                    ma[lo[i]] = dat[i][7:0];
                end else begin
                    merr = 1'b1;
                end
            end
        end
        if (clr_left > 0) begin
            k = 9 - clr_left;
            if (k < 8) ma[k] = 8'h00;
            else mb = 16'h0;
            clr_left--;
        end else if (clr) begin
            clr_left = 9;
        end
    endfunction

    task automatic cyc();
        logic [1:0] er;
        @(negedge clk);
        s_rdy  = rdy;
        s_busy = busy;
        s_st   = st;
        er     = m_ready();
        chk("model_req_ready", 80'(rdy), 80'(er));
        @(posedge clk);
        m_step(er);
        #1;
        chk("model_state_o", st, m_state());
        chk("model_busy", 80'(busy), 80'(clr_left != 0));
        chk("model_wr_err", 80'(wr_err), 80'(merr));
    endtask

    task automatic set_req(input int i, input logic f, input logic [2:0] l,
                           input logic [2:0] h, input logic [15:0] d);
        fld[i] = f;
        lo[i]  = l;
        hi[i]  = h;
        dat[i] = d;
    endtask

    initial begin
        logic [79:0] st0;
        logic [79:0] ex;

        tbl[0] = '{2'b01, 1'b0, 3'd1, 3'd2, 16'h1234, 2'b01, 80'h0000_0000_0012_3400_0000, 1'b0};
        tbl[1] = '{2'b00, 1'b0, 3'd0, 3'd0, 16'h0000, 2'b00, 80'h0000_0000_0012_3400_0000, 1'b0};
        tbl[2] = '{2'b10, 1'b0, 3'd5, 3'd5, 16'h0042, 2'b10, 80'h0000_4200_0012_3400_0000, 1'b0};
        tbl[3] = '{2'b00, 1'b0, 3'd0, 3'd0, 16'h0000, 2'b00, 80'h0000_4200_0012_3400_0000, 1'b0};
        tbl[4] = '{2'b01, 1'b1, 3'd6, 3'd1, 16'hFFFC, 2'b01, 80'h0000_4200_0012_3400_FFFC, 1'b0};
        tbl[5] = '{2'b00, 1'b0, 3'd0, 3'd0, 16'h0000, 2'b00, 80'h0000_4200_0012_3400_FFFC, 1'b0};
        tbl[6] = '{2'b01, 1'b0, 3'd3, 3'd2, 16'hBEEF, 2'b01, 80'h0000_4200_0012_3400_FFFC, 1'b1};
        tbl[7] = '{2'b00, 1'b0, 3'd0, 3'd0, 16'h0000, 2'b00, 80'h0000_4200_0012_3400_FFFC, 1'b0};

        rst = 1'b1; vld = 2'b00; fld = 2'b00; lo = '0; hi = '0; dat = '0; clr = 1'b0;
        m_reset();
        cyc();
        cyc();
        rst = 1'b0;
        chk("reset_state", st, 80'h0);
        chk("reset_busy", 80'(busy), 80'h0);
        chk("reset_wr_err", 80'(wr_err), 80'h0);

        // Round robin with both requesters held valid (writes of zero to b).
        vld = 2'b11; fld = 2'b11; dat = '0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("rr_grant", 80'(s_rdy), 80'((k % 2 == 0) ? 2'b01 : 2'b10));
            chk("rr_onehot", 80'($countones(s_rdy)), 80'd1);
        end
        vld = 2'b00;
        cyc();

        for (int n = 0; n < 8; n++) begin
            vld = tbl[n].v;
            for (int i = 0; i < 2; i++) set_req(i, tbl[n].f, tbl[n].l, tbl[n].h, tbl[n].d);
            cyc();
            chk("tbl_ready", 80'(s_rdy), 80'(tbl[n].er));
            chk("tbl_state", st, tbl[n].es);
            chk("tbl_wr_err", 80'(wr_err), 80'(tbl[n].ee));
        end

        // Clear sequence with both requesters pushing throughout.
        st0 = st;
        vld = 2'b00; clr = 1'b1;
        cyc();
        clr = 1'b0; vld = 2'b11;
        for (int i = 0; i < 2; i++) set_req(i, 1'b0, 3'd0, 3'd1, 16'hAAAA);
        for (int k = 0; k < 9; k++) begin
            cyc();
            chk("clr_busy", 80'(s_busy), 80'h1);
            chk("clr_ready_blocked", 80'(s_rdy), 80'h0);
            ex = st0;
            if (k < 8) begin
                for (int j = 0; j <= k; j++) ex[16+8*j +: 8] = 8'h00;
            end else begin
                ex = '0;
            end
            chk("clr_progress", st, ex);
        end
        vld = 2'b00;
        cyc();
        chk("clr_busy_fall", 80'(s_busy), 80'h0);

        // Reset while clearing element 4.
        vld = 2'b01; set_req(0, 1'b1, 3'd0, 3'd0, 16'hABCD);
        cyc();
        vld = 2'b10; set_req(1, 1'b0, 3'd6, 3'd7, 16'h5A5A);
        cyc();
        vld = 2'b00; clr = 1'b1;
        cyc();
        clr = 1'b0;
        for (int k = 0; k < 4; k++) cyc();
        rst = 1'b1;
        cyc();
        chk("midclr_was_busy", 80'(s_busy), 80'h1);
        chk("midclr_upper_bytes", 80'(s_st[79:64]), 80'h5A5A);
        chk("midclr_reset_state", st, 80'h0);
        chk("midclr_reset_busy", 80'(busy), 80'h0);
        rst = 1'b0;
        vld = 2'b10; set_req(1, 1'b0, 3'd0, 3'd0, 16'h0055);
        cyc();
        chk("post_reset_grant1", 80'(s_rdy), 80'h2);
        chk("post_reset_write", st, 80'h0000_0000_0000_0055_0000);

        // Clear start in the same cycle as a write to a[7].
        vld = 2'b10; set_req(1, 1'b0, 3'd7, 3'd7, 16'h00FF); clr = 1'b1;
        cyc();
        chk("same_cycle_grant", 80'(s_rdy), 80'h2);
        clr = 1'b0; vld = 2'b00;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("a7_held", 80'(s_st[79:72]), 80'hFF);
        end
        chk("a7_cleared", 80'(st[79:72]), 80'h00);
        cyc();
        chk("same_cycle_final", st, 80'h0);
        cyc();
        chk("same_cycle_idle", 80'(s_busy), 80'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            vld = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) begin
                fld[i] = ($urandom_range(0, 3) == 0);
                lo[i]  = 3'($urandom_range(0, 7));
                hi[i]  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                     : 3'(lo[i] + 3'($urandom_range(0, 1)));
                dat[i] = 16'($urandom);
            end
            clr = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 99) == 0);
            cyc();
        end
        rst = 1'b0; vld = 2'b00; clr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
